// File: rtl/rv32_dbg_trigger_unit.sv
// NUM_BP-entry hardware breakpoint/trigger unit with a debug APB slave and a registered halt request.
// Optional per-entry skip counter in BPn_CTRL[31:16] is built when DBG_TRIG_COUNT_EN is defined.
module rv32_dbg_trigger_unit #(
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [11:0]     paddr,
    input  logic [31:0]     pwdata,
    output logic [31:0]     prdata,
    output logic            pready,
    output logic            pslverr,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            resume_i,
    output logic            bp_hit_o,
    output logic [3:0]      hit_idx_o,
    output logic [3:0]      halt_cause_o
);

    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 16;
    localparam logic [3:0]  HALT_NONE  = 4'b0000;
    localparam logic [3:0]  HALT_BREAKPOINT = 4'b0010;
    localparam logic [1:0]  MODE_EXEC  = 2'b00;
    localparam logic [1:0]  MODE_LOAD  = 2'b01;
    localparam logic [1:0]  MODE_STORE = 2'b10;

    // Per-entry configuration
    logic [XLEN-1:0]   bp_addr    [NUM_BP];
    logic              bp_en      [NUM_BP];
    logic [1:0]        bp_mode    [NUM_BP];
    logic              bp_oneshot [NUM_BP];
`ifdef DBG_TRIG_COUNT_EN
    logic [CNT_W-1:0]  bp_count   [NUM_BP];
    logic [NUM_BP-1:0] skip_c;
`endif
    logic [NUM_BP-1:0] trig_status;
    logic              suppress_q;

    // APB decode
    logic              access_c;
    logic              in_bp_win_c;
    logic [IDX_W-1:0]  entry_idx_c;
    logic              is_ctrl_c;
    logic              entry_ok_c;
    logic              status_sel_c;
    logic [NUM_BP-1:0] wr_addr_c;
    logic [NUM_BP-1:0] wr_ctrl_c;
    logic              wr_status_c;
    logic [31:0]       rdata_c;

    // Match path
    logic              exec_block_c;
    logic [NUM_BP-1:0] match_c;
    logic [NUM_BP-1:0] fire_c;
    logic [IDX_W-1:0]  hit_idx_c;

    logic              unused_pwdata;
    assign unused_pwdata = ^pwdata;

    assign pready = 1'b1;

    // Address decode: entries live in 0x100..0x17C, status at 0x180, word aligned only
    always_comb begin
        access_c     = psel && penable;
        in_bp_win_c  = (paddr[11:7] == 5'b00010) && (paddr[1:0] == 2'b00);
        entry_idx_c  = paddr[6:3];
        is_ctrl_c    = paddr[2];
        entry_ok_c   = in_bp_win_c && (32'(entry_idx_c) < NUM_BP);
        status_sel_c = (paddr == 12'h180);
        wr_status_c  = access_c && pwrite && status_sel_c;
        wr_addr_c    = '0;
        wr_ctrl_c    = '0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (access_c && pwrite && entry_ok_c && (entry_idx_c == 4'(i))) begin
                wr_addr_c[i] = !is_ctrl_c;
                wr_ctrl_c[i] = is_ctrl_c;
            end
        end
    end

    // Read mux and error response, valid only during the access phase
    always_comb begin
        rdata_c = '0;
        if (status_sel_c) begin
            rdata_c = 32'(trig_status);
        end else if (entry_ok_c) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                if (entry_idx_c == 4'(i)) begin
                    if (is_ctrl_c) begin
`ifdef DBG_TRIG_COUNT_EN
                        rdata_c = {bp_count[i], 12'b0, bp_oneshot[i], bp_mode[i], bp_en[i]};
`else
                        rdata_c = {28'b0, bp_oneshot[i], bp_mode[i], bp_en[i]};
`endif
                    end else begin
                        rdata_c = 32'(bp_addr[i]);
                    end
                end
            end
        end
        prdata  = access_c ? rdata_c : 32'b0;
        pslverr = access_c && !(entry_ok_c || status_sel_c);
    end

    // Execute matches are blocked for the first pc_valid_i at or after resume
    assign exec_block_c = suppress_q || resume_i;

    // Per-entry match and fire evaluation against current (pre-write) configuration
    always_comb begin
        match_c = '0;
        fire_c  = '0;
`ifdef DBG_TRIG_COUNT_EN
        skip_c  = '0;
`endif
        for (int i = 0; i < int'(NUM_BP); i++) begin
            unique case (bp_mode[i])
                MODE_EXEC:  match_c[i] = pc_valid_i && !exec_block_c && (pc_i == bp_addr[i]);
                MODE_LOAD:  match_c[i] = mem_read_i && (mem_addr_i == bp_addr[i]);
                MODE_STORE: match_c[i] = mem_write_i && (mem_addr_i == bp_addr[i]);
                default:    match_c[i] = (mem_read_i || mem_write_i) && (mem_addr_i == bp_addr[i]);
            endcase
            match_c[i] = match_c[i] && bp_en[i];
`ifdef DBG_TRIG_COUNT_EN
            skip_c[i] = match_c[i] && (bp_count[i] != '0);
            fire_c[i] = match_c[i] && (bp_count[i] == '0);
`else
            fire_c[i] = match_c[i];
`endif
        end
    end

    // Lowest firing index wins
    always_comb begin
        hit_idx_c = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (fire_c[i]) hit_idx_c = 4'(i);
        end
    end

    // Entry registers: APB write takes priority over one-shot clear and count decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                bp_addr[i]    <= '0;
                bp_en[i]      <= 1'b0;
                bp_mode[i]    <= 2'b00;
                bp_oneshot[i] <= 1'b0;
`ifdef DBG_TRIG_COUNT_EN
                bp_count[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                if (wr_addr_c[i]) bp_addr[i] <= XLEN'(pwdata);
                if (wr_ctrl_c[i]) begin
                    bp_en[i]      <= pwdata[0];
                    bp_mode[i]    <= pwdata[2:1];
                    bp_oneshot[i] <= pwdata[3];
`ifdef DBG_TRIG_COUNT_EN
                    bp_count[i]   <= pwdata[31:16];
`endif
                end else begin
                    if (fire_c[i] && bp_oneshot[i]) bp_en[i] <= 1'b0;
`ifdef DBG_TRIG_COUNT_EN
                    if (skip_c[i]) bp_count[i] <= bp_count[i] - CNT_W'(1);
`endif
                end
            end
        end
    end

    // Sticky status: a new hit beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_status <= '0;
        end else if (wr_status_c) begin
            trig_status <= (trig_status & ~pwdata[NUM_BP-1:0]) | fire_c;
        end else begin
            trig_status <= trig_status | fire_c;
        end
    end

    // Resume-suppress flag consumed by the next pc_valid_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suppress_q <= 1'b0;
        end else begin
            suppress_q <= exec_block_c && !pc_valid_i;
        end
    end

    // Registered halt request to the CPU control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit_o     <= 1'b0;
            hit_idx_o    <= '0;
            halt_cause_o <= HALT_NONE;
        end else begin
            bp_hit_o     <= |fire_c;
            hit_idx_o    <= hit_idx_c;
            halt_cause_o <= (|fire_c) ? HALT_BREAKPOINT : HALT_NONE;
        end
    end

endmodule

// File: tb/tb_rv32_dbg_trigger_unit.sv
// Directed bench for rv32_dbg_trigger_unit with a software-view reference model.
// Builds with or without DBG_TRIG_COUNT_EN, matching the RTL build.
module tb_rv32_dbg_trigger_unit;

    localparam int unsigned NUM_BP = 2;
    localparam int unsigned XLEN   = 32;
`ifdef DBG_TRIG_COUNT_EN
    localparam logic [31:0] CTRL_MASK = 32'hFFFF_000F;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0]     paddr = '0;
    logic [31:0]     pwdata = '0;
    logic [31:0]     prdata;
    logic            pready, pslverr;
    logic [XLEN-1:0] pc_i = '0;
    logic            pc_valid_i = 1'b0;
    logic [XLEN-1:0] mem_addr_i = '0;
    logic            mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic            resume_i = 1'b0;
    logic            bp_hit_o;
    logic [3:0]      hit_idx_o, halt_cause_o;

    int vectors = 0;
    int miscompares = 0;
    bit run = 1'b0;

    rv32_dbg_trigger_unit #(.NUM_BP(NUM_BP), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .mem_addr_i(mem_addr_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .resume_i(resume_i),
        .bp_hit_o(bp_hit_o), .hit_idx_o(hit_idx_o), .halt_cause_o(halt_cause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as software sees them, updated once per clock
    logic [31:0]       m_addr [NUM_BP];
    logic [31:0]       m_ctrl [NUM_BP];
    logic [NUM_BP-1:0] m_status;
    bit                m_supp;
    bit                exp_hit;
    int                exp_idx;
    logic [3:0]        exp_cause;

    function automatic bit m_entry_ok(input logic [11:0] a);
        return (int'(a) >= 'h100) && (int'(a) < 'h100 + 8 * int'(NUM_BP)) && (int'(a) % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int n;
        if (a == 12'h180) return 32'(m_status);
        if (m_entry_ok(a)) begin
            n = (int'(a) - 'h100) / 8;
            return ((int'(a) % 8) == 4) ? m_ctrl[n] : m_addr[n];
        end
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [NUM_BP-1:0] fires;
        logic [31:0]       nctrl [NUM_BP];
        bit                blk, m;
        int                n;
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_BP); i++) begin
                m_addr[i] = '0;
                m_ctrl[i] = '0;
            end
            m_status = '0; m_supp = 0; exp_hit = 0; exp_idx = 0; exp_cause = 4'd0;
        end else begin
            blk = m_supp || resume_i;
            fires = '0;
            for (int i = 0; i < int'(NUM_BP); i++) begin
                nctrl[i] = m_ctrl[i];
                m = 0;
                if (m_ctrl[i][0]) begin
                    case (m_ctrl[i][2:1])
                        2'd0: m = pc_valid_i && !blk && (pc_i == m_addr[i]);
                        2'd1: m = mem_read_i && (mem_addr_i == m_addr[i]);
                        2'd2: m = mem_write_i && (mem_addr_i == m_addr[i]);
                        default: m = (mem_read_i || mem_write_i) && (mem_addr_i == m_addr[i]);
                    endcase
                end
                if (m) begin
`ifdef DBG_TRIG_COUNT_EN
                    if (m_ctrl[i][31:16] != 16'd0) nctrl[i] = m_ctrl[i] - 32'h0001_0000;
                    else fires[i] = 1'b1;
`else
                    fires[i] = 1'b1;
`endif
                    if (fires[i] && m_ctrl[i][3]) nctrl[i][0] = 1'b0;
                end
            end
            if (psel && penable && pwrite) begin
                if (paddr == 12'h180) begin
                    m_status = m_status & ~pwdata[NUM_BP-1:0];
                end else if (m_entry_ok(paddr)) begin
                    n = (int'(paddr) - 'h100) / 8;
                    if ((int'(paddr) % 8) == 4) nctrl[n] = pwdata & CTRL_MASK;
                    else m_addr[n] = pwdata;
                end
            end
            for (int i = 0; i < int'(NUM_BP); i++) m_ctrl[i] = nctrl[i];
            m_status = m_status | fires;
            exp_hit = |fires;
            exp_idx = 0;
            for (int i = int'(NUM_BP) - 1; i >= 0; i--) if (fires[i]) exp_idx = i;
            exp_cause = exp_hit ? 4'b0010 : 4'b0000;
            m_supp = blk && !pc_valid_i;
        end
    end

    // Per-cycle comparison of the halt request against the model
    always @(negedge clk) begin
        if (rst_n && run) begin
            chk("bp_hit", 32'(bp_hit_o), 32'(exp_hit));
            chk("halt_cause", 32'(halt_cause_o), 32'(exp_cause));
            if (exp_hit) chk("hit_idx", 32'(hit_idx_o), 32'(exp_idx));
        end
    end

    task automatic apb(input logic [11:0] a, input logic [31:0] d, input bit wr,
                       output logic [31:0] rd, output logic err);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1;
        #1;
        rd = prdata; err = pslverr;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd; logic err;
        apb(a, d, 1'b1, rd, err);
        chk("wr_pslverr", 32'(err), 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] lit);
        logic [31:0] rd; logic err;
        apb(a, 32'h0, 1'b0, rd, err);
        chk(name, rd, lit);
        chk({name, "_model"}, rd, m_read(a));
        chk({name, "_pslverr"}, 32'(err), 32'h0);
    endtask

    task automatic err_chk(input string name, input logic [11:0] a, input logic [31:0] d, input bit w);
        logic [31:0] rd; logic err;
        apb(a, d, w, rd, err);
        chk({name, "_pslverr"}, 32'(err), 32'h1);
        if (!w) chk({name, "_prdata"}, rd, 32'h0);
    endtask

    task automatic drive_pc(input logic [31:0] a);
        pc_i = a; pc_valid_i = 1;
        @(negedge clk);
        pc_valid_i = 0;
    endtask

    task automatic drive_mem(input logic [31:0] a, input bit r, input bit w);
        mem_addr_i = a; mem_read_i = r; mem_write_i = w;
        @(negedge clk);
        mem_read_i = 0; mem_write_i = 0;
    endtask

    task automatic hit_lit(input string name, input bit h, input logic [3:0] idx);
        chk({name, "_hit"}, 32'(bp_hit_o), 32'(h));
        chk({name, "_cause"}, 32'(halt_cause_o), h ? 32'h2 : 32'h0);
        if (h) chk({name, "_idx"}, 32'(hit_idx_o), 32'(idx));
    endtask

    initial begin
        #2;
        chk("rst_bp_hit", 32'(bp_hit_o), 32'h0);
        chk("rst_hit_idx", 32'(hit_idx_o), 32'h0);
        chk("rst_cause", 32'(halt_cause_o), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_pready", 32'(pready), 32'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        run = 1;
        rd_chk("rst_bp0_addr", 12'h100, 32'h0);
        rd_chk("rst_bp1_ctrl", 12'h10C, 32'h0);
        rd_chk("rst_status", 12'h180, 32'h0);

        // Basic execute breakpoint
        wr(12'h100, 32'h40);
        wr(12'h104, 32'h1);
        drive_pc(32'h40);
        hit_lit("exec", 1, 4'd0);
        @(negedge clk);
        hit_lit("exec_single", 0, 4'd0);
        rd_chk("exec_status", 12'h180, 32'h1);

        // Step off after resume
        resume_i = 1; @(negedge clk); resume_i = 0;
        drive_pc(32'h40);
        hit_lit("resume_supp", 0, 4'd0);
        drive_pc(32'h40);
        hit_lit("resume_second", 1, 4'd0);
        wr(12'h180, 32'h1);
        rd_chk("w1c_status", 12'h180, 32'h0);
        // resume and pc_valid together: that instruction is the suppressed one
        pc_i = 32'h40; pc_valid_i = 1; resume_i = 1;
        @(negedge clk);
        resume_i = 0; pc_valid_i = 0;
        hit_lit("resume_same", 0, 4'd0);
        drive_pc(32'h40);
        hit_lit("resume_same_next", 1, 4'd0);
        wr(12'h180, 32'h1);

        // One-shot store breakpoint on BP1
        wr(12'h108, 32'h2000);
        wr(12'h10C, 32'hD);
        mem_addr_i = 32'h2000; mem_write_i = 1;
        @(negedge clk);
        hit_lit("store_first", 1, 4'd1);
        @(negedge clk);
        mem_write_i = 0;
        hit_lit("store_oneshot", 0, 4'd0);
        rd_chk("oneshot_ctrl", 12'h10C, 32'hC);
        wr(12'h10C, 32'hD);
        drive_mem(32'h2000, 1, 0);
        hit_lit("store_on_load", 0, 4'd0);
        // CTRL write in the same cycle as a one-shot hit: match fires, write wins
        psel = 1; pwrite = 1; paddr = 12'h10C; pwdata = 32'hD;
        @(negedge clk);
        penable = 1; mem_addr_i = 32'h2000; mem_write_i = 1;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0; mem_write_i = 0;
        hit_lit("wr_vs_oneshot", 1, 4'd1);
        rd_chk("wr_vs_oneshot_ctrl", 12'h10C, 32'hD);
        rd_chk("store_status", 12'h180, 32'h2);
        wr(12'h180, 32'h3);

        // Both entries on the same PC
        wr(12'h100, 32'h80);
        wr(12'h108, 32'h80);
        wr(12'h10C, 32'h1);
        drive_pc(32'h80);
        hit_lit("dual", 1, 4'd0);
        @(negedge clk);
        hit_lit("dual_single", 0, 4'd0);
        rd_chk("dual_status", 12'h180, 32'h3);
        // W1C of bit 0 coincident with a fresh hit
        psel = 1; pwrite = 1; paddr = 12'h180; pwdata = 32'h1;
        @(negedge clk);
        penable = 1; pc_i = 32'h80; pc_valid_i = 1;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0; pc_valid_i = 0;
        hit_lit("w1c_vs_set", 1, 4'd0);
        rd_chk("w1c_vs_set_status", 12'h180, 32'h3);
        // Back-to-back instructions
        pc_i = 32'h80; pc_valid_i = 1;
        @(negedge clk);
        hit_lit("b2b_1", 1, 4'd0);
        @(negedge clk);
        pc_valid_i = 0;
        hit_lit("b2b_2", 1, 4'd0);
        wr(12'h180, 32'h3);

        // Load-or-store mode on BP1, no execute match
        wr(12'h108, 32'h300);
        wr(12'h10C, 32'h7);
        drive_mem(32'h300, 1, 0);
        hit_lit("ls_load", 1, 4'd1);
        drive_mem(32'h300, 0, 1);
        hit_lit("ls_store", 1, 4'd1);
        drive_mem(32'h304, 1, 1);
        hit_lit("ls_other_addr", 0, 4'd0);
        drive_pc(32'h300);
        hit_lit("ls_pc", 0, 4'd0);
        wr(12'h180, 32'h3);

        // Unmapped addresses
        err_chk("rd_110", 12'h110, 32'h0, 0);
        err_chk("wr_110", 12'h110, 32'hFFFF_FFFF, 1);
        err_chk("rd_17c", 12'h17C, 32'h0, 0);
        err_chk("rd_184", 12'h184, 32'h0, 0);
        err_chk("rd_000", 12'h000, 32'h0, 0);
        rd_chk("after_bad_wr_bp0a", 12'h100, 32'h80);
        rd_chk("after_bad_wr_bp0c", 12'h104, 32'h1);
        rd_chk("after_bad_wr_bp1a", 12'h108, 32'h300);
        rd_chk("after_bad_wr_bp1c", 12'h10C, 32'h7);

        // Skip count field
        wr(12'h100, 32'h40);
        wr(12'h104, 32'h0002_0001);
`ifdef DBG_TRIG_COUNT_EN
        rd_chk("cnt_ctrl_load", 12'h104, 32'h0002_0001);
        drive_pc(32'h40);
        hit_lit("cnt_m1", 0, 4'd0);
        drive_pc(32'h40);
        hit_lit("cnt_m2", 0, 4'd0);
        drive_pc(32'h40);
        hit_lit("cnt_m3", 1, 4'd0);
        rd_chk("cnt_ctrl_after", 12'h104, 32'h0000_0001);
`else
        rd_chk("cnt_ctrl_ignored", 12'h104, 32'h0000_0001);
        drive_pc(32'h40);
        hit_lit("nocnt_m1", 1, 4'd0);
`endif
        @(negedge clk);

        // Asynchronous reset while a pulse is on the output
        drive_pc(32'h40);
        chk("pre_reset_hit", 32'(bp_hit_o), 32'h1);
        #1 rst_n = 0;
        #1;
        chk("async_rst_hit", 32'(bp_hit_o), 32'h0);
        chk("async_rst_cause", 32'(halt_cause_o), 32'h0);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        hit_lit("post_reset", 0, 4'd0);
        rd_chk("post_rst_bp0a", 12'h100, 32'h0);
        rd_chk("post_rst_bp0c", 12'h104, 32'h0);
        rd_chk("post_rst_status", 12'h180, 32'h0);
        drive_pc(32'h40);
        hit_lit("post_rst_nomatch", 0, 4'd0);
        repeat (2) @(negedge clk);

        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32_dbg_trigger_unit.md
# rv32_dbg_trigger_unit

Parametrised hardware breakpoint/trigger unit for the RV32I core's debug subsystem. It generalises the fixed two-entry BP0/BP1 register pair to NUM_BP entries. Each entry matches on execute, load or store addresses. Entries are configured over the debug APB slave, and hits are reported to the CPU control FSM as a registered halt request with cause HALT_BREAKPOINT.

## Interface
Parameters:
- NUM_BP, 2, number of trigger entries (1..16)
- XLEN, 32, address/data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  12  APB byte address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready; tied 1
- pslverr  out  1  APB error
- pc_i  in  XLEN  PC of instruction entering EXECUTE
- pc_valid_i  in  1  pc_i qualifier, one cycle per instruction
- mem_addr_i  in  XLEN  data access address
- mem_read_i  in  1  load access this cycle
- mem_write_i  in  1  store access this cycle
- resume_i  in  1  single-cycle pulse, CPU leaving CPU_HALTED
- bp_hit_o  out  1  single-cycle halt request
- hit_idx_o  out  4  lowest-index entry that caused bp_hit_o
- halt_cause_o  out  4  HALT_BREAKPOINT while bp_hit_o, else HALT_NONE

## Operation
- Register map per entry n: BPn_ADDR at 0x100+8n, BPn_CTRL at 0x104+8n. TRIG_STATUS at 0x180 holds sticky hit bits [NUM_BP-1:0], write-1-to-clear.
- BPn_CTRL fields: [0] enable; [2:1] mode (00 execute on pc_i, 01 load, 10 store, 11 load or store); [3] one-shot, which clears enable on hit. Other bits are reserved and read 0.
- Match rule: enable && the qualifier for the selected mode is high && the compared address == BPn_ADDR, compared over the full XLEN bits.
- Execute matches are suppressed for exactly the first pc_valid_i after resume_i. This lets the core step off a breakpointed PC. Memory matches are not suppressed.
- Any entry firing in cycle N causes the following in cycle N+1:
  - bp_hit_o=1 for one cycle.
  - hit_idx_o = lowest firing index.
  - All firing entries set their TRIG_STATUS bit.
- APB: zero wait states. Writes commit on the access phase (psel && penable && pwrite). prdata is driven combinationally from registers during the access phase and is 0 otherwise.
- pslverr=1 in the access phase for an unmapped address. This includes entries n >= NUM_BP and any address outside 0x100..0x17C or 0x180. Writes to such addresses are dropped.

## Timing
- Reset values:
  - All ADDR, CTRL and STATUS registers are 0; the resume-suppress flag is 0.
  - bp_hit_o, hit_idx_o, halt_cause_o, prdata and pslverr are 0.
  - pready is 1.
- Match-to-hit latency is exactly 1 cycle. Back-to-back matching cycles produce back-to-back bp_hit_o pulses.
- An APB write to BPn in the same cycle as a match: the match uses the pre-write values. The APB write wins over a one-shot enable clear.
- A TRIG_STATUS W1C in the same cycle as a new hit on that bit: set wins.
- resume_i and pc_valid_i in the same cycle: that pc_valid_i is the suppressed one.
- rst_n asserted mid-operation clears all state asynchronously. No pulse is emitted after deassertion.

## Configuration
- DBG_TRIG_COUNT_EN defined:
  - BPn_CTRL[31:16] is a skip count.
  - A match with a nonzero count decrements it and does not fire.
  - A match with a zero count fires.
  - An APB write to CTRL reloads the count.
- DBG_TRIG_COUNT_EN undefined: bits [31:16] read 0 and ignore writes, and every match fires.

## Test plan
- Program BP0_ADDR=0x0000_0040 and BP0_CTRL=0x1. Drive pc_i=0x40 with pc_valid_i → bp_hit_o pulses one cycle later, hit_idx_o=0, halt_cause_o=4'b0010, and a TRIG_STATUS read returns 0x1.
- Pulse resume_i, then drive pc_i=0x40 twice → no hit on the first, hit on the second. Write 0x1 to TRIG_STATUS → status reads 0.
- BP1 in store mode at 0x2000 with the one-shot bit (CTRL=0xD). Drive mem_write_i at 0x2000 twice → one pulse only, hit_idx_o=1, BP1_CTRL reads 0xC. mem_read_i at 0x2000 → no hit.
- BP0 and BP1 both execute-mode at 0x80, one match → a single pulse, hit_idx_o=0, TRIG_STATUS=0x3. A W1C of 0x1 in the same cycle as a fresh BP0 hit → bit 0 stays set.
- NUM_BP=2: read 0x110 → pslverr=1, prdata=0. Write 0x110 → no register changes.
- With DBG_TRIG_COUNT_EN, CTRL=0x0002_0001: three matches → a pulse only on the third, and CTRL[31:16] reads 0 after it.
